// File: rtl/ysyx_23060240_sram_arbiter_if.sv
// Bus bundle between IFU/LSU requesters, the SRAM arbiter and the downstream SRAM model.
// slave = arbiter side, master = environment side (requesters + memory).
interface ysyx_23060240_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_23060240_sram_arbiter.sv
// Single-outstanding arbiter sharing one SRAM port between IFU fetches and LSU loads/stores.
// Define ARB_ROUND_ROBIN_EN to replace fixed LSU priority with 1-bit round-robin on contention.
module ysyx_23060240_sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input logic                           clk,
    input logic                           rst,
    ysyx_23060240_sram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              mem_req_valid_q, mem_req_valid_d;

    logic              grant_ifu, grant_lsu;
    logic              ifu_ready, lsu_ready;
    logic              resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_lsu_q, last_lsu_d;

    // On contention the requester that did not win last time is served.
    always_comb begin
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            grant_lsu = ~last_lsu_q;
            grant_ifu = last_lsu_q;
        end else begin
            grant_lsu = bus.lsu_req_valid;
            grant_ifu = bus.ifu_req_valid;
        end
    end
`else
    always_comb begin
        grant_lsu = bus.lsu_req_valid;
        grant_ifu = bus.ifu_req_valid & ~bus.lsu_req_valid;
    end
`endif

    assign ifu_ready = ~rst & (state_q == IDLE) & grant_ifu;
    assign lsu_ready = ~rst & (state_q == IDLE) & grant_lsu;
    assign resp_fire = ~rst & (state_q == RESP) & bus.mem_resp_valid;

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_lsu_d  = last_lsu_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (lsu_ready) begin
                    state_d     = REQ;
                    owner_lsu_d = 1'b1;
                    we_d        = bus.lsu_we;
                    addr_d      = bus.lsu_addr;
                    wdata_d     = bus.lsu_wdata;
                    wmask_d     = bus.lsu_wmask;
`ifdef ARB_ROUND_ROBIN_EN
                    last_lsu_d  = 1'b1;
`endif
                end else if (ifu_ready) begin
                    state_d     = REQ;
                    owner_lsu_d = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = bus.ifu_addr;
                    wdata_d     = '0;
                    wmask_d     = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_lsu_d  = 1'b0;
`endif
                end
            end
            REQ:  if (bus.mem_req_ready)  state_d = RESP;
            RESP: if (bus.mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        mem_req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_lsu_q     <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q      <= 1'b1;
`endif
        end else begin
            state_q         <= state_d;
            owner_lsu_q     <= owner_lsu_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            mem_req_valid_q <= mem_req_valid_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu_q      <= last_lsu_d;
`endif
        end
    end

    assign bus.ifu_req_ready  = ifu_ready;
    assign bus.lsu_req_ready  = lsu_ready;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_we         = we_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    // Response data is forwarded only to the owner, and only during the pulse.
    assign bus.ifu_resp_valid = resp_fire & ~owner_lsu_q;
    assign bus.lsu_resp_valid = resp_fire & owner_lsu_q;
    assign bus.ifu_rdata      = (resp_fire & ~owner_lsu_q) ? bus.mem_rdata : '0;
    assign bus.lsu_rdata      = (resp_fire & owner_lsu_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_ysyx_23060240_sram_arbiter.sv
// Scoreboard bench for the SRAM arbiter: transaction-level reference model, random memory timing.
module tb_ysyx_23060240_sram_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_23060240_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();
    ysyx_23060240_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {bit lsu; bit we; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask;} req_t;
    typedef struct {bit we; logic [31:0] data;} rsp_t;

    int total = 0;
    int bad = 0;

    // reference model state (transaction phase: 0 idle, 1 request out, 2 awaiting response)
    int          phase = 0;
    bit          owner_lsu = 0;
    bit          last_lsu = 1;
    req_t        mem_exp[$];
    logic [31:0] ifu_exp[$];
    rsp_t        lsu_exp[$];
    bit          grant_log[$];
    int          req_len = 0;
    int          last_req_len = 0;
    int          ifu_rsp_n = 0;
    int          lsu_rsp_n = 0;

    // memory stimulus knobs
    int rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int hold_req = 0;   // ready forced low for the first N cycles of a request
    int dmin = 1;
    int dmax = 1;
    int stray_div = 0;  // 0 off, else 1-in-N stray responses while no response is due

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], a[31:16]} ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ifu_issue(input logic [31:0] a);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = a;
        ifu_exp.push_back(mem_word(a));
        do begin @(negedge clk); n++; end while (!bus.ifu_req_ready && n < 1000);
        if (!bus.ifu_req_ready) begin
            total++; bad++;
            $display("FAIL ifu_accept_timeout: got no ready expected ready for addr %h", a);
        end
        @(posedge clk); #1;
        bus.ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [7:0] wm);
        int n;
        rsp_t r;
        n = 0;
        @(posedge clk); #1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = we;
        bus.lsu_addr      = a;
        bus.lsu_wdata     = wd;
        bus.lsu_wmask     = wm;
        r.we = we; r.data = mem_word(a);
        lsu_exp.push_back(r);
        do begin @(negedge clk); n++; end while (!bus.lsu_req_ready && n < 1000);
        if (!bus.lsu_req_ready) begin
            total++; bad++;
            $display("FAIL lsu_accept_timeout: got no ready expected ready for addr %h", a);
        end
        @(posedge clk); #1;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while ((phase != 0 || ifu_exp.size() != 0 || lsu_exp.size() != 0) && n < 500);
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL idle_timeout: got phase %0d ifu_q %0d lsu_q %0d expected idle and empty",
                     phase, ifu_exp.size(), lsu_exp.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chkb({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chkb({tag, "_mem_we"}, bus.mem_we, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'h0);
        chkb({tag, "_ifu_ready"}, bus.ifu_req_ready, 1'b0);
        chkb({tag, "_lsu_ready"}, bus.lsu_req_ready, 1'b0);
        chkb({tag, "_ifu_resp"}, bus.ifu_resp_valid, 1'b0);
        chkb({tag, "_lsu_resp"}, bus.lsu_resp_valid, 1'b0);
    endtask

    function automatic int glog(input int i);
        if (i < grant_log.size()) return int'(grant_log[i]);
        return 2;
    endfunction

    // monitor: transaction-level reference model, compared every cycle away from the clock edge
    initial begin
        bit gi, gl, ifv, lsv;
        req_t q;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                phase = 0;
                last_lsu = 1'b1;
                mem_exp.delete();
                ifu_exp.delete();
                lsu_exp.delete();
            end else begin
                ifv = bus.ifu_req_valid;
                lsv = bus.lsu_req_valid;
                gi = 1'b0;
                gl = 1'b0;
                if (phase == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (ifv && lsv) begin gl = !last_lsu; gi = last_lsu; end
                    else begin gl = lsv; gi = ifv; end
`else
                    gl = lsv;
                    gi = ifv && !lsv;
`endif
                end
                chkb("ifu_req_ready", bus.ifu_req_ready, gi);
                chkb("lsu_req_ready", bus.lsu_req_ready, gl);
                chkb("mem_req_valid", bus.mem_req_valid, phase == 1);
                chkb("ifu_resp_valid", bus.ifu_resp_valid, phase == 2 && bus.mem_resp_valid && !owner_lsu);
                chkb("lsu_resp_valid", bus.lsu_resp_valid, phase == 2 && bus.mem_resp_valid && owner_lsu);

                if (bus.ifu_resp_valid) begin
                    ifu_rsp_n++;
                    if (ifu_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ifu_resp_unexpected: got pulse expected none");
                    end else chk("ifu_rdata", bus.ifu_rdata, ifu_exp.pop_front());
                end else chk("ifu_rdata_idle", bus.ifu_rdata, 32'h0);

                if (bus.lsu_resp_valid) begin
                    lsu_rsp_n++;
                    if (lsu_exp.size() == 0) begin
                        total++; bad++;
                        $display("FAIL lsu_resp_unexpected: got pulse expected none");
                    end else begin
                        r = lsu_exp.pop_front();
                        if (!r.we) chk("lsu_rdata", bus.lsu_rdata, r.data);
                    end
                end else chk("lsu_rdata_idle", bus.lsu_rdata, 32'h0);

                if (phase == 1 && mem_exp.size() != 0) begin
                    req_len++;
                    chkb("mem_we", bus.mem_we, mem_exp[0].we);
                    chk("mem_addr", bus.mem_addr, mem_exp[0].addr);
                    if (mem_exp[0].lsu) begin
                        chk("mem_wdata", bus.mem_wdata, mem_exp[0].wdata);
                        chk("mem_wmask", 32'(bus.mem_wmask), 32'(mem_exp[0].wmask));
                    end
                end

                if (phase == 0 && (gi || gl)) begin
                    q.lsu = gl;
                    q.we = gl ? bus.lsu_we : 1'b0;
                    q.addr = gl ? bus.lsu_addr : bus.ifu_addr;
                    q.wdata = bus.lsu_wdata;
                    q.wmask = bus.lsu_wmask;
                    mem_exp.push_back(q);
                    owner_lsu = gl;
                    last_lsu = gl;
                    grant_log.push_back(gl);
                    req_len = 0;
                    phase = 1;
                end else if (phase == 1 && bus.mem_req_ready) begin
                    last_req_len = req_len;
                    void'(mem_exp.pop_front());
                    phase = 2;
                end else if (phase == 2 && bus.mem_resp_valid) begin
                    phase = 0;
                end
            end
        end
    end

    // downstream memory: drives ready/response timing, returns the reference contents
    initial begin
        logic [31:0] a;
        bit w;
        int d, vcnt;
        vcnt = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata = '0;
            if (stray_div != 0 && $urandom_range(0, stray_div - 1) == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata = $urandom;
            end
            if (bus.mem_req_valid) vcnt++; else vcnt = 0;
            if (bus.mem_req_valid && vcnt <= hold_req) bus.mem_req_ready = 1'b0;
            else if (rdy_mode == 0) bus.mem_req_ready = 1'($urandom_range(0, 1));
            else bus.mem_req_ready = (rdy_mode == 1);
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                a = bus.mem_addr;
                w = bus.mem_we;
                d = $urandom_range(dmin, dmax);
                repeat (d) begin
                    @(posedge clk); #1;
                    bus.mem_resp_valid = 1'b0;
                    bus.mem_rdata = '0;
                    bus.mem_req_ready = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata = w ? $urandom : mem_word(a);
                bus.mem_req_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, ifu_n, lsu_n;
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr = '0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_we = 1'b0;
        bus.lsu_addr = '0;
        bus.lsu_wdata = '0;
        bus.lsu_wmask = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single IFU fetch
        ifu_issue(32'h8000_0000);
        wait_idle();

        // stray responses in IDLE, then in REQ with ready held low
        stray_div = 1;
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        ifu_issue(32'h8000_0010);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chkb("stray_req_held", bus.mem_req_valid, 1'b1);
        stray_div = 0;
        rdy_mode = 1;
        wait_idle();

        // LSU write with downstream back-pressure
        hold_req = 3;
        lsu_issue(1'b1, 32'h8000_2000, 32'hDEAD_BEEF, 8'h0F);
        wait_idle();
        chk("wr_req_len", 32'(last_req_len), 32'd4);
        hold_req = 0;

        // simultaneous requests
        base = grant_log.size();
        fork
            ifu_issue(32'h8000_0004);
            lsu_issue(1'b0, 32'h8000_1000, 32'h0, 8'h0);
        join
        wait_idle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("contend_first", 32'(glog(base)), 32'd0);
        chk("contend_second", 32'(glog(base + 1)), 32'd1);
`else
        chk("contend_first", 32'(glog(base)), 32'd1);
        chk("contend_second", 32'(glog(base + 1)), 32'd0);
`endif

        // reset while waiting for the response; the late response must be dropped
        dmin = 4;
        dmax = 4;
        lsu_issue(1'b0, 32'h8000_3000, 32'h0, 8'h0);
        n = 0;
        while (phase != 2 && n < 100) begin @(negedge clk); n++; end
        chk("rst_reached_resp", 32'(phase), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_rst");
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) n++;
        end
        chk("post_rst_pulses", 32'(n), 32'd0);
        dmin = 1;
        dmax = 1;

        // sustained contention, two requests from each side
        base = grant_log.size();
        fork
            begin ifu_issue(32'h8000_0020); ifu_issue(32'h8000_0024); end
            begin lsu_issue(1'b0, 32'h8000_4000, 32'h0, 8'h0); lsu_issue(1'b1, 32'h8000_4004, 32'h1234_5678, 8'hF0); end
        join
        wait_idle();
`ifdef ARB_ROUND_ROBIN_EN
        chk("order0", 32'(glog(base)), 32'd0);
        chk("order1", 32'(glog(base + 1)), 32'd1);
        chk("order2", 32'(glog(base + 2)), 32'd0);
        chk("order3", 32'(glog(base + 3)), 32'd1);
`else
        chk("order0", 32'(glog(base)), 32'd1);
        chk("order1", 32'(glog(base + 1)), 32'd1);
        chk("order2", 32'(glog(base + 2)), 32'd0);
        chk("order3", 32'(glog(base + 3)), 32'd0);
`endif

        // randomized traffic
        rdy_mode = 0;
        dmin = 0;
        dmax = 3;
        stray_div = 8;
        ifu_n = ifu_rsp_n;
        lsu_n = lsu_rsp_n;
        fork
            for (int i = 0; i < 50; i++) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                ifu_issue(32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4);
            end
            for (int j = 0; j < 50; j++) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                lsu_issue(1'($urandom_range(0, 1)), 32'h8000_8000 + 32'($urandom_range(0, 1023)) * 4,
                          $urandom, 8'($urandom_range(0, 255)));
            end
        join
        stray_div = 0;
        wait_idle();
        chk("rand_ifu_count", 32'(ifu_rsp_n - ifu_n), 32'd50);
        chk("rand_lsu_count", 32'(lsu_rsp_n - lsu_n), 32'd50);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
